// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: x = a - b - bin, one digit per clock, LSD first.
// Optional macro BCD_SUB_SIGN_EN adds a FIX pass returning negative results as sign-magnitude.
module bcd_serial_subtractor #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] x,
  output logic                bout,
  output logic                neg,
  output logic                err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
`ifdef BCD_SUB_SIGN_EN
    FIX  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state, next_state;
  logic [W-1:0]     a_q, b_q, acc;
  logic [IDX_W-1:0] idx;
  logic             borrow, raw_bout, err_q;
`ifdef BCD_SUB_SIGN_EN
  logic             neg_q;
`endif

  logic [3:0] op_a, op_b, digit_res;
  logic       op_bin, borrow_nxt, last_digit;
  logic [4:0] diff;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Shared digit subtractor: SUB uses captured operands, FIX computes 0 - x_k - fb
  always_comb begin
    op_a   = a_q[{idx, 2'b00} +: 4];
    op_b   = b_q[{idx, 2'b00} +: 4];
    op_bin = borrow;
`ifdef BCD_SUB_SIGN_EN
    if (state == FIX) begin
      op_a = 4'd0;
      op_b = acc[{idx, 2'b00} +: 4];
    end
`endif
    diff       = {1'b0, op_a} - {1'b0, op_b} - 5'(op_bin);
    borrow_nxt = diff[4];
    digit_res  = diff[4] ? 4'(diff + 5'd10) : diff[3:0];
    last_digit = (idx == IDX_W'(DIGITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = SUB;
      SUB: begin
        if (last_digit) begin
`ifdef BCD_SUB_SIGN_EN
          next_state = borrow_nxt ? FIX : DONE;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGN_EN
      FIX:  if (last_digit) next_state = DONE;
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture and digit-serial working registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      idx      <= '0;
      borrow   <= 1'b0;
      raw_bout <= 1'b0;
      err_q    <= 1'b0;
`ifdef BCD_SUB_SIGN_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            idx    <= '0;
            err_q  <= has_bad_digit(a) | has_bad_digit(b);
`ifdef BCD_SUB_SIGN_EN
            neg_q  <= 1'b0;
`endif
          end
        end
        SUB: begin
          acc[{idx, 2'b00} +: 4] <= digit_res;
          if (last_digit) begin
            idx      <= '0;
            raw_bout <= borrow_nxt;
            borrow   <= 1'b0;
          end else begin
            idx    <= idx + IDX_W'(1);
            borrow <= borrow_nxt;
          end
        end
`ifdef BCD_SUB_SIGN_EN
        FIX: begin
          acc[{idx, 2'b00} +: 4] <= digit_res;
          borrow <= borrow_nxt;
          if (last_digit) begin
            idx   <= '0;
            neg_q <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Result outputs change only when leaving DONE; an error zeroes the numeric result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      x    <= '0;
      bout <= 1'b0;
      neg  <= 1'b0;
      err  <= 1'b0;
    end else begin
      busy <= (next_state != IDLE) && (state != DONE);
      done <= (state == DONE);
      if (state == DONE) begin
        x    <= err_q ? '0 : acc;
        bout <= err_q ? 1'b0 : raw_bout;
`ifdef BCD_SUB_SIGN_EN
        neg  <= err_q ? 1'b0 : neg_q;
`else
        neg  <= 1'b0;
`endif
        err  <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed self-checking bench for bcd_serial_subtractor (DIGITS=4), either setting of BCD_SUB_SIGN_EN.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst, start, bin;
  logic [15:0] a, b, x;
  logic        busy, done, bout, neg, err;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int done_seen;

`ifdef BCD_SUB_SIGN_EN
  localparam int NEG_LAT = 9;
  localparam logic [15:0] NEG_X = 16'h0001;
  localparam logic NEG_FLAG = 1'b1;
`else
  localparam int NEG_LAT = 5;
  localparam logic [15:0] NEG_X = 16'h9999;
  localparam logic NEG_FLAG = 1'b0;
`endif

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .x(x), .bout(bout), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally re-pulse start mid-run, then check latency, result and the pulse width
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tbin, input bit poke, input int lat,
                        input logic [15:0] ex, input logic eb, input logic en, input logic ee);
    int n;
    @(negedge clk);
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hFFFF; b = 16'h7777; bin = ~tbin;
    check({tag, ".busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (poke && n == 2) begin
        start = 1'b1; a = 16'h0000; b = 16'h0001;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, ".lat"}, 32'(n), 32'(lat));
    check({tag, ".x"}, 32'(x), 32'(ex));
    check({tag, ".bout"}, 32'(bout), 32'(eb));
    check({tag, ".neg"}, 32'(neg), 32'(en));
    check({tag, ".err"}, 32'(err), 32'(ee));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    check({tag, ".x_held"}, 32'(x), 32'(ex));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.x", 32'(x), 32'd0);
    check("reset.flags", {29'd0, bout, neg, err}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("basic",   16'h4321, 16'h1234, 1'b0, 1'b0, 5,       16'h3087, 1'b0, 1'b0,     1'b0);
    run_op("ripple",  16'h1000, 16'h0001, 1'b0, 1'b0, 5,       16'h0999, 1'b0, 1'b0,     1'b0);
    run_op("neg",     16'h0000, 16'h0001, 1'b0, 1'b0, NEG_LAT, NEG_X,    1'b1, NEG_FLAG, 1'b0);
    run_op("neg_bin", 16'h0005, 16'h0005, 1'b1, 1'b0, NEG_LAT, NEG_X,    1'b1, NEG_FLAG, 1'b0);
    run_op("err",     16'h00A0, 16'h0001, 1'b0, 1'b0, 5,       16'h0000, 1'b0, 1'b0,     1'b1);
    run_op("poke",    16'h4321, 16'h1234, 1'b0, 1'b1, 5,       16'h3087, 1'b0, 1'b0,     1'b0);

    // Reset in the third SUB cycle aborts with no done pulse
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort.x", 32'(x), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.flags", {29'd0, bout, neg, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'd0);
    check("abort.idle_busy", 32'(busy), 32'd0);

    run_op("fresh",   16'h9999, 16'h1111, 1'b0, 1'b0, 5,       16'h8888, 1'b0, 1'b0,     1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
